// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out handshake bundle: serial source on one side, word consumer on the other.
// The master modport is the environment side; the deserializer uses the slave modport.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;

    modport master (
        output sin, sin_valid, dout_ready,
        input  sin_ready, dout, dout_valid, busy
    );

    modport slave (
        input  sin, sin_valid, dout_ready,
        output sin_ready, dout, dout_valid, busy
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Assembles a 1-bit serial stream into WIDTH-bit words with valid/ready on both sides.
// A completed word that finds the output slot occupied is parked in the shift register (STALL).
//
// state     | meaning
// S_COLLECT | accepting serial bits, sin_ready=1
// S_STALL   | full word parked in r_sr waiting for the output slot, sin_ready=0
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    sipo_deserializer_if.slave    bus
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_STALL   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    logic             w_accept;
    logic             w_consume;
    logic             w_last;
    logic             w_slot_free;
    logic [WIDTH-1:0] w_sr_next;

    assign w_accept    = bus.sin_valid && (r_state == S_COLLECT);
    assign w_consume   = r_dout_valid && bus.dout_ready;
    assign w_last      = w_accept && (r_cnt == CNT_LAST);
    assign w_slot_free = !r_dout_valid || bus.dout_ready;
    assign w_sr_next   = MSB_FIRST ? {r_sr[WIDTH-2:0], bus.sin} : {bus.sin, r_sr[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_clr) begin
            w_state_next = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_last && !w_slot_free) w_state_next = S_STALL;
                S_STALL:   if (w_consume)              w_state_next = S_COLLECT;
                default:                               w_state_next = S_COLLECT;
            endcase
        end
    end

    always_comb begin
        bus.sin_ready = (r_state == S_COLLECT);
        bus.busy      = (r_cnt != '0) || (r_state == S_STALL);
    end

    // A parked word in r_sr is only released into r_dout on a consume while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr         <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (i_clr) begin
            r_sr         <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sr  <= w_sr_next;
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (w_last && w_slot_free) begin
                r_dout       <= w_sr_next;
                r_dout_valid <= 1'b1;
            end else if ((r_state == S_STALL) && w_consume) begin
                r_dout       <= r_sr;
                r_dout_valid <= 1'b1;
            end else if (w_consume) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Drives an MSB-first and an LSB-first deserializer with the same stimulus and compares both
// against a word-level model (collected bit list, parked word, output slot) every cycle.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) bus_m ();
    sipo_deserializer_if #(.WIDTH(W)) bus_l ();

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .bus     (bus_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .bus     (bus_l)
    );

    // model: index 0 = MSB-first instance, 1 = LSB-first instance
    int         m_nb   [2];
    bit         m_bitv [2][W];
    bit         m_pend [2];
    bit [W-1:0] m_pword[2];
    bit [W-1:0] m_dout [2];
    bit         m_dv   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [W-1:0] pack_word(input int k);
        bit [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (k == 0) w[W-1-i] = m_bitv[k][i];
            else        w[i]     = m_bitv[k][i];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_nb[k]    = 0;
            m_pend[k]  = 1'b0;
            m_pword[k] = '0;
            m_dout[k]  = '0;
            m_dv[k]    = 1'b0;
        end
    endtask

    task automatic model_edge(input int k, input bit s, input bit sv, input bit dr, input bit c);
        bit dv_before, accept, consume;
        if (c) begin
            m_nb[k]   = 0;
            m_pend[k] = 1'b0;
            m_dout[k] = '0;
            m_dv[k]   = 1'b0;
            return;
        end
        dv_before = m_dv[k];
        accept    = sv && !m_pend[k];
        consume   = dv_before && dr;
        if (accept) begin
            m_bitv[k][m_nb[k]] = s;
            m_nb[k]++;
        end
        if (consume) begin
            if (m_pend[k]) begin
                m_dout[k] = m_pword[k];
                m_pend[k] = 1'b0;
            end else begin
                m_dv[k] = 1'b0;
            end
        end
        if (accept && m_nb[k] == W) begin
            m_nb[k] = 0;
            if (!dv_before || dr) begin
                m_dout[k] = pack_word(k);
                m_dv[k]   = 1'b1;
            end else begin
                m_pword[k] = pack_word(k);
                m_pend[k]  = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("m_dout",      32'(bus_m.dout),       32'(m_dout[0]));
        chk("m_dout_valid", 32'(bus_m.dout_valid), 32'(m_dv[0]));
        chk("m_sin_ready", 32'(bus_m.sin_ready),  32'(!m_pend[0]));
        chk("m_busy",      32'(bus_m.busy),       32'((m_nb[0] != 0) || m_pend[0]));
        chk("l_dout",      32'(bus_l.dout),       32'(m_dout[1]));
        chk("l_dout_valid", 32'(bus_l.dout_valid), 32'(m_dv[1]));
        chk("l_sin_ready", 32'(bus_l.sin_ready),  32'(!m_pend[1]));
        chk("l_busy",      32'(bus_l.busy),       32'((m_nb[1] != 0) || m_pend[1]));
    endtask

    task automatic drive(input bit s, input bit sv, input bit dr, input bit c);
        bus_m.sin = s;  bus_m.sin_valid = sv;  bus_m.dout_ready = dr;
        bus_l.sin = s;  bus_l.sin_valid = sv;  bus_l.dout_ready = dr;
        clr = c;
    endtask

    task automatic cycle(input bit s, input bit sv, input bit dr, input bit c);
        drive(s, sv, dr, c);
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) model_edge(k, s, sv, dr, c);
        end
        #1;
        check_all();
    endtask

    task automatic send_bits(input bit [7:0] bits, input int n, input bit dr);
        for (int i = 0; i < n; i++) cycle(bits[n-1-i], 1'b1, dr, 1'b0);
    endtask

    initial begin
        bit [W-1:0] tmp;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;

        // 1,0,1,1 with ready: word visible right after the 4th edge, for one cycle
        send_bits(8'b1011, 4, 1'b1);
        chk("t1_dout_m", 32'(bus_m.dout), 32'h0B);
        chk("t1_dv_m",   32'(bus_m.dout_valid), 32'd1);
        chk("t1_dout_l", 32'(bus_l.dout), 32'h0D);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_dv_drop", 32'(bus_m.dout_valid), 32'd0);

        // back-to-back words, no bubble
        for (int i = 0; i < 8; i++) begin
            tmp = 4'(8'b1011_0110 >> (7 - i));
            cycle(tmp[0], 1'b1, 1'b1, 1'b0);
            chk("t2_sin_ready", 32'(bus_m.sin_ready), 32'd1);
            if (i == 3) chk("t2_w0", 32'(bus_m.dout), 32'h0B);
            if (i == 7) chk("t2_w1", 32'(bus_m.dout), 32'h06);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // backpressure: second word parks, then released by one consume
        send_bits(8'b1011_0110, 8, 1'b0);
        chk("t3_hold_m",   32'(bus_m.dout), 32'h0B);
        chk("t3_hold_l",   32'(bus_l.dout), 32'h0D);
        chk("t3_ready",    32'(bus_m.sin_ready), 32'd0);
        chk("t3_busy",     32'(bus_m.busy), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_stall_drop", 32'(bus_m.busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_rel_m",    32'(bus_m.dout), 32'h06);
        chk("t3_rel_l",    32'(bus_l.dout), 32'h06);
        chk("t3_rel_dv",   32'(bus_m.dout_valid), 32'd1);
        chk("t3_rel_ready", 32'(bus_m.sin_ready), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_drain", 32'(bus_m.dout_valid), 32'd0);

        // clear mid-word discards partial bits and the same-cycle bit
        send_bits(8'b11, 2, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_busy", 32'(bus_m.busy), 32'd0);
        send_bits(8'b0010, 4, 1'b1);
        chk("t4_dout_m", 32'(bus_m.dout), 32'h02);
        chk("t4_dout_l", 32'(bus_l.dout), 32'h04);

        // async reset between edges after two bits
        send_bits(8'b10, 2, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t5_busy_now", 32'(bus_m.busy), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #3 rst_n = 1'b1;
        send_bits(8'b0101, 4, 1'b1);
        chk("t5_dout_m", 32'(bus_m.dout), 32'h05);
        chk("t5_dout_l", 32'(bus_l.dout), 32'h0A);

        // 1,0,1,1 with random gaps
        for (int i = 0; i < 4; i++) begin
            tmp = 4'b1011;
            repeat ($urandom_range(0, 3)) cycle(1'($urandom), 1'b0, 1'b1, 1'b0);
            cycle(tmp[3-i], 1'b1, 1'b1, 1'b0);
        end
        chk("t6_dout_l", 32'(bus_l.dout), 32'h0D);
        chk("t6_dout_m", 32'(bus_m.dout), 32'h0B);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
